// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU weight-port / MultAdder arbiter.
//   - Datapath widths of block_mem and TPU_MultAdd.
//   - Arbiter state encoding (IDLE, OWN0, OWN1, DRAIN).
//   - Requester ids (FC1 = 0, FC2 = 1) and an id -> one-hot helper.
package tpu_pkg;

    localparam int unsigned ADDR_W = 11;    // weight ROM address width
    localparam int unsigned ROM_W  = 2048;  // weight ROM data width (128 x 16b)
    localparam int unsigned OPR_W  = 2048;  // MultAdder operand width (128 x 16b)
    localparam int unsigned RES_W  = 31;    // MultAdder result width

    localparam logic REQ_FC1 = 1'b0;
    localparam logic REQ_FC2 = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StOwn0  = ST_OWN0,
        StOwn1  = ST_OWN1,
        StDrain = ST_DRAIN
    } arb_state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == REQ_FC2) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-latency tracker for the shared weight ROM.
// A Depth-deep shift register of {valid, requester id}; an entry pushed on the edge that
// registers rom_addr comes out as a one-cycle rom_vld pulse Depth cycles after that edge,
// aligned with block_mem douta.
// Ports:
//   clk        clock, rising edge
//   iRst       asynchronous active-high reset, drops every in-flight tag
//   push_i     an access was accepted this cycle
//   push_id_i  id of the accepting requester
//   vld_o      one-hot ROM data valid per requester (registered)
module arb_tag_pipe
    import tpu_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk,
    input  logic       iRst,
    input  logic       push_i,
    input  logic       push_id_i,
    output logic [1:0] vld_o
);

    logic [Depth-1:0] vld_q;
    logic [Depth-1:0] id_q;
    logic [1:0]       vld_out_q;

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            vld_q     <= '0;
            id_q      <= '0;
            vld_out_q <= 2'b00;
        end else begin
            vld_q[0] <= push_i;
            id_q[0]  <= push_id_i;
            for (int unsigned k = 1; k < Depth; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
            vld_out_q <= vld_q[Depth-1] ? id_to_onehot(id_q[Depth-1]) : 2'b00;
        end
    end

    assign vld_o = vld_out_q;

endmodule

// File: rtl/tpu_shared_mac_arbiter.sv
// Arbiter sharing the single weight block_mem port and the single TPU_MultAdd between
// full_connect1 (req 0) and full_connect2 (req 1) with registered grants.
// Optional feature macro: ARB_PERF_CNT_EN adds busy_cyc0/busy_cyc1, free-running 32-bit
// counts of cycles each requester held the grant.
// Ports:
//   clk, iRst            clock / asynchronous active-high reset
//   ena                  low = no new accesses accepted (grant is held)
//   req, last            per-requester access request and end-of-burst marker
//   addr0/1              ROM addresses from the requesters
//   opr1_0/1, opr2_0/1   MultAdder operands from the requesters
//   clr_ovf              clear sticky overflow per requester (a new overflow wins)
//   gnt                  registered one-hot grant
//   rom_addr, rom_data   block_mem addra / douta
//   rom_rd, rom_vld      ROM data broadcast and per-requester valid
//   mac_opr1/2           TPU_MultAdd operands (owner's, else zero)
//   mac_res, mac_ovf     TPU_MultAdd result / overflow
//   res, res_vld, ovf    registered result, per-requester valid, sticky overflow
module tpu_shared_mac_arbiter
    import tpu_pkg::*;
#(
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              iRst,
    input  logic              ena,
    input  logic [1:0]        req,
    input  logic [1:0]        last,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [OPR_W-1:0]  opr1_0,
    input  logic [OPR_W-1:0]  opr1_1,
    input  logic [OPR_W-1:0]  opr2_0,
    input  logic [OPR_W-1:0]  opr2_1,
    input  logic [1:0]        clr_ovf,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic [ROM_W-1:0]  rom_rd,
    output logic [1:0]        rom_vld,
    output logic [OPR_W-1:0]  mac_opr1,
    output logic [OPR_W-1:0]  mac_opr2,
    input  logic [RES_W-1:0]  mac_res,
    input  logic              mac_ovf,
    output logic [RES_W-1:0]  res,
    output logic [1:0]        res_vld,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       busy_cyc0,
    output logic [31:0]       busy_cyc1,
`endif
    output logic [1:0]        ovf
);

    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    localparam int unsigned DrainW = $clog2(ROM_LAT + 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              rr_q, rr_d;        // id that wins the next simultaneous request
    logic [BurstW-1:0] burst_q, burst_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [RES_W-1:0]  res_q;
    logic [1:0]        res_vld_q;
    logic [1:0]        ovf_q, ovf_d;

    logic       owner;    // meaningful only while gnt_q is non-zero
    logic [1:0] acc;
    logic       acc_any;
    logic       win;

    assign owner   = gnt_q[REQ_FC2];
    assign acc     = {2{ena}} & gnt_q & req;
    assign acc_any = |acc;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        drain_d = drain_q;
        win     = rr_q;
        unique case (state_q)
            StIdle: begin
                if (ena && (req != 2'b00)) begin
                    win     = (req == 2'b11) ? rr_q : req[REQ_FC2];
                    gnt_d   = id_to_onehot(win);
                    state_d = win ? StOwn1 : StOwn0;
                    burst_d = '0;
                end
            end
            StOwn0, StOwn1: begin
                if (acc_any) begin
                    burst_d = burst_q + BurstW'(1);
                end
                // A dropped request ends the burst even while ena is low.
                if (!req[owner] ||
                    (acc_any && (last[owner] || burst_q == BurstW'(MAX_BURST - 1)))) begin
                    gnt_d   = 2'b00;
                    state_d = StDrain;
                    burst_d = '0;
                    drain_d = '0;
                    rr_d    = ~owner;
                end
            end
            StDrain: begin
                // Hold off re-granting until the last issued read has returned.
                if (drain_q == DrainW'(ROM_LAT - 1)) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // New overflow on the same edge as a clear takes precedence.
    assign ovf_d = (ovf_q & ~clr_ovf) | (acc & {2{mac_ovf}});

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q    <= StIdle;
            gnt_q      <= 2'b00;
            rr_q       <= REQ_FC1;
            burst_q    <= '0;
            drain_q    <= '0;
            rom_addr_q <= '0;
            res_q      <= '0;
            res_vld_q  <= 2'b00;
            ovf_q      <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            drain_q <= drain_d;
            if (acc_any) begin
                rom_addr_q <= owner ? addr1 : addr0;
                res_q      <= mac_res;
            end
            res_vld_q <= acc;
            ovf_q     <= ovf_d;
        end
    end

    arb_tag_pipe #(
        .Depth (ROM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .iRst      (iRst),
        .push_i    (acc_any),
        .push_id_i (owner),
        .vld_o     (rom_vld)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] busy0_q, busy1_q;

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            busy0_q <= '0;
            busy1_q <= '0;
        end else begin
            if (gnt_q[REQ_FC1]) busy0_q <= busy0_q + 32'd1;
            if (gnt_q[REQ_FC2]) busy1_q <= busy1_q + 32'd1;
        end
    end

    assign busy_cyc0 = busy0_q;
    assign busy_cyc1 = busy1_q;
`endif

    // Operands are forced to zero between grants so the MultAdder never sees floating data.
    assign mac_opr1 = gnt_q[REQ_FC1] ? opr1_0 : (gnt_q[REQ_FC2] ? opr1_1 : '0);
    assign mac_opr2 = gnt_q[REQ_FC1] ? opr2_0 : (gnt_q[REQ_FC2] ? opr2_1 : '0);

    assign gnt      = gnt_q;
    assign rom_addr = rom_addr_q;
    assign rom_rd   = rom_data;
    assign res      = res_q;
    assign res_vld  = res_vld_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_tpu_shared_mac_arbiter.sv
`timescale 1ns/1ps
module tb_tpu_shared_mac_arbiter;
    import tpu_pkg::*;

    localparam int unsigned ROM_LAT   = 1;
    localparam int unsigned MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              iRst;
    logic              ena;
    logic [1:0]        req, last, clr_ovf;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [OPR_W-1:0]  opr1_0, opr1_1, opr2_0, opr2_1;
    logic [1:0]        gnt, rom_vld, res_vld, ovf;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data, rom_rd;
    logic [OPR_W-1:0]  mac_opr1, mac_opr2;
    logic [RES_W-1:0]  mac_res, res;
    logic              mac_ovf;

    always #5 clk = ~clk;

    tpu_shared_mac_arbiter #(
        .ROM_LAT   (ROM_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .iRst     (iRst),
        .ena      (ena),
        .req      (req),
        .last     (last),
        .addr0    (addr0),
        .addr1    (addr1),
        .opr1_0   (opr1_0),
        .opr1_1   (opr1_1),
        .opr2_0   (opr2_0),
        .opr2_1   (opr2_1),
        .clr_ovf  (clr_ovf),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_rd   (rom_rd),
        .rom_vld  (rom_vld),
        .mac_opr1 (mac_opr1),
        .mac_opr2 (mac_opr2),
        .mac_res  (mac_res),
        .mac_ovf  (mac_ovf),
        .res      (res),
        .res_vld  (res_vld),
        .ovf      (ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (low 64 bits) at %0t",
                     nm, act[63:0], exp[63:0], $time);
        end
    endtask

    // Reference model: owner id (-1 = none), cycles left before a new grant, scheduled reads.
    int                m_owner, m_drain, m_rr, m_burst, m_cyc;
    logic [ADDR_W-1:0] m_rom_addr;
    logic [RES_W-1:0]  m_res;
    logic [1:0]        m_res_vld, m_rom_vld, m_ovf;
    int                due_q[$];
    int                id_q[$];

    task automatic model_reset();
        m_owner = -1; m_drain = 0; m_rr = 0; m_burst = 0; m_cyc++;
        m_rom_addr = '0; m_res = '0; m_res_vld = 2'b00; m_rom_vld = 2'b00; m_ovf = 2'b00;
        due_q.delete(); id_q.delete();
    endtask

    task automatic model_edge();
        int acc;
        int n;
        n = m_cyc + 1;
        m_cyc = n;
        acc = -1;
        if (m_owner >= 0 && ena && req[m_owner]) acc = m_owner;
        for (int i = 0; i < 2; i++) begin
            if (clr_ovf[i]) m_ovf[i] = 1'b0;
            if (acc == i && mac_ovf) m_ovf[i] = 1'b1;
        end
        m_res_vld = 2'b00;
        if (acc >= 0) begin
            m_res = mac_res;
            m_res_vld[acc] = 1'b1;
            m_rom_addr = (acc == 0) ? addr0 : addr1;
            due_q.push_back(n + ROM_LAT);
            id_q.push_back(acc);
            m_burst++;
        end
        if (m_owner >= 0) begin
            if (!req[m_owner] || (acc >= 0 && (last[m_owner] || m_burst == MAX_BURST))) begin
                m_rr = 1 - m_owner; m_owner = -1; m_drain = ROM_LAT; m_burst = 0;
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (ena && req != 2'b00) begin
            m_owner = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
            m_burst = 0;
        end
        m_rom_vld = 2'b00;
        if (due_q.size() > 0 && due_q[0] == n) begin
            m_rom_vld[id_q[0]] = 1'b1;
            void'(due_q.pop_front());
            void'(id_q.pop_front());
        end
    endtask

    task automatic check_all();
        logic [1:0]       eg;
        logic [OPR_W-1:0] e1, e2;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        e1 = (m_owner == 0) ? opr1_0 : ((m_owner == 1) ? opr1_1 : '0);
        e2 = (m_owner == 0) ? opr2_0 : ((m_owner == 1) ? opr2_1 : '0);
        chk("gnt", gnt, eg);
        chk("rom_addr", rom_addr, m_rom_addr);
        chk("rom_vld", rom_vld, m_rom_vld);
        chk("res", res, m_res);
        chk("res_vld", res_vld, m_res_vld);
        chk("ovf", ovf, m_ovf);
        chk("mac_opr1", mac_opr1, e1);
        chk("mac_opr2", mac_opr2, e2);
        chk("rom_rd", rom_rd, rom_data);
    endtask

    task automatic tick();
        if (iRst) model_reset(); else model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_wide(output logic [2047:0] v);
        for (int k = 0; k < 64; k++) v[k*32 +: 32] = $urandom;
    endtask

    task automatic idle_inputs();
        ena = 1'b1; req = 2'b00; last = 2'b00; clr_ovf = 2'b00; mac_ovf = 1'b0;
        addr0 = '0; addr1 = '0; mac_res = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRst = 1'b1;
        tick();
        tick();
        iRst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]        req;
        logic [1:0]        last;
        logic [ADDR_W-1:0] a0;
        logic [RES_W-1:0]  mres;
        logic [1:0]        e_gnt;
        logic [ADDR_W-1:0] e_addr;
        logic [1:0]        e_rvld;
        logic [1:0]        e_resvld;
        logic [RES_W-1:0]  e_res;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int pulses;
        logic [1:0] seen;

        // Three accesses by requester 0 (addr 5,6,7), last on the third.
        tbl[0] = '{2'b01, 2'b00, 11'd5, 31'd11,  2'b01, 11'd0, 2'b00, 2'b00, 31'd0};
        tbl[1] = '{2'b01, 2'b00, 11'd5, 31'd100, 2'b01, 11'd5, 2'b00, 2'b01, 31'd100};
        tbl[2] = '{2'b01, 2'b00, 11'd6, 31'd200, 2'b01, 11'd6, 2'b01, 2'b01, 31'd200};
        tbl[3] = '{2'b01, 2'b01, 11'd7, 31'd300, 2'b00, 11'd7, 2'b01, 2'b01, 31'd300};
        tbl[4] = '{2'b00, 2'b00, 11'd7, 31'd400, 2'b00, 11'd7, 2'b01, 2'b00, 31'd300};
        tbl[5] = '{2'b00, 2'b00, 11'd7, 31'd500, 2'b00, 11'd7, 2'b00, 2'b00, 31'd300};

        m_cyc = 0;
        rand_wide(opr1_0); rand_wide(opr1_1); rand_wide(opr2_0); rand_wide(opr2_1);
        rand_wide(rom_data);
        do_reset();
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_ovf", ovf, 2'b00);

        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; last = tbl[i].last; addr0 = tbl[i].a0; mac_res = tbl[i].mres;
            tick();
            chk("tbl_gnt", gnt, tbl[i].e_gnt);
            chk("tbl_rom_addr", rom_addr, tbl[i].e_addr);
            chk("tbl_rom_vld", rom_vld, tbl[i].e_rvld);
            chk("tbl_res_vld", res_vld, tbl[i].e_resvld);
            chk("tbl_res", res, tbl[i].e_res);
        end

        // Round-robin on simultaneous requests, single-access bursts.
        do_reset();
        req = 2'b11; last = 2'b11;
        tick();
        chk("tie_first", gnt, 2'b01);
        tick(); tick(); tick();
        chk("tie_second", gnt, 2'b10);
        tick(); tick(); tick();
        chk("tie_third", gnt, 2'b01);

        // Requester 1 exceeds MAX_BURST while requester 0 waits.
        do_reset();
        req = 2'b10;
        tick();
        chk("burst_gnt1", gnt, 2'b10);
        req = 2'b11;
        for (int i = 0; i < 15; i++) begin
            addr1 = ADDR_W'(i + 1);
            tick();
        end
        chk("burst_hold", gnt, 2'b10);
        tick();
        chk("burst_drop", gnt, 2'b00);
        for (int i = 0; i < ROM_LAT + 1; i++) tick();
        chk("burst_next", gnt, 2'b01);

        // Sticky overflow, set-wins-over-clear.
        do_reset();
        req = 2'b01;
        tick();
        mac_ovf = 1'b1;
        tick();
        chk("ovf_set", ovf, 2'b01);
        clr_ovf = 2'b01;
        tick();
        chk("ovf_set_wins", ovf, 2'b01);
        mac_ovf = 1'b0;
        tick();
        chk("ovf_clear", ovf, 2'b00);
        clr_ovf = 2'b00;

        // ena low mid-burst: grant held, address frozen, pending read still returns once.
        do_reset();
        req = 2'b01; addr0 = 11'd20;
        tick();
        tick();
        ena = 1'b0; addr0 = 11'd21;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rom_vld[0]) pulses++;
        end
        chk("ena_low_pulses", pulses, 1);
        chk("ena_low_addr", rom_addr, 11'd20);
        chk("ena_low_gnt", gnt, 2'b01);
        ena = 1'b1;
        tick();
        chk("ena_resume_addr", rom_addr, 11'd21);

        // Asynchronous reset one cycle after an acceptance.
        do_reset();
        req = 2'b01; addr0 = 11'd9; mac_res = 31'h1234;
        tick();
        tick();
        iRst = 1'b1;
        #1;
        chk("rst_async_gnt", gnt, 2'b00);
        chk("rst_async_addr", rom_addr, 11'd0);
        chk("rst_async_res", res, 31'd0);
        chk("rst_async_vld", {rom_vld, res_vld}, 4'b0000);
        tick();
        iRst = 1'b0; req = 2'b00;
        seen = 2'b00;
        for (int i = 0; i < ROM_LAT + 3; i++) begin
            tick();
            seen = seen | rom_vld | res_vld;
        end
        chk("rst_no_pulse", seen, 2'b00);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                last[i]    = ($urandom_range(0, 3) == 0);
                clr_ovf[i] = ($urandom_range(0, 7) == 0);
            end
            ena     = ($urandom_range(0, 7) != 0);
            mac_ovf = ($urandom_range(0, 7) == 0);
            addr0   = ADDR_W'($urandom);
            addr1   = ADDR_W'($urandom);
            mac_res = RES_W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rand_wide(opr1_0); rand_wide(opr2_1); rand_wide(rom_data);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
